bcd_subtractor: RTL and testbench

Registered N-digit BCD subtractor computing |a − b| in BCD, plus a sign/no-borrow flag. It uses the 9's-complement method with end-around carry, built from per-digit BCD adder cells. It sits in the datapath as a pipelined arithmetic unit with one register stage, and a valid strobe travels alongside the data. Inputs containing non-BCD digits (1010–1111) are flagged, not computed.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adder.sv | 20 ++
 rtl/bcd_subtractor.sv | 95 +++++++++
 tb/tb_bcd_subtractor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and digit helpers for the BCD subtractor.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic bcd_digit_t nines_comp(input bcd_digit_t digit);
        return BCD_MAX - digit;
    endfunction

    function automatic logic is_bcd(input bcd_digit_t digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit cell: binary add with +6 decimal correction.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] bin;

    always_comb begin
        bin  = {1'b0, x} + {1'b0, y} + {4'd0, cin};
        cout = bin > 5'd9;
        sum  = cout ? (bin[3:0] + 4'd6) : bin[3:0];
    end

endmodule

// File: rtl/bcd_subtractor.sv
// Registered N-digit BCD |a - b| using 9's complement and
// end-around carry, with sign (cout) and invalid-digit flag.
module bcd_subtractor
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [4*NUM_DIGITS-1:0] a,
    input  logic [4*NUM_DIGITS-1:0] b,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] s,
    output logic                    cout,
    output logic                    err
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0]          b_nc;
    logic [W-1:0]          sum1;
    logic [W-1:0]          sum2;
    logic [W-1:0]          mag_neg;
    logic [NUM_DIGITS:0]   c1;
    logic [NUM_DIGITS:0]   c2;
    logic [NUM_DIGITS-1:0] dig_bad;

    logic [W-1:0] s_d, s_q;
    logic         cout_d, cout_q;
    logic         err_d, err_q;
    logic         out_valid_q;
    logic         nonneg;

    assign c1[0] = 1'b0;
    assign c2[0] = 1'b1;

    // The +1 ripple always runs; its carry-out only rises when sum1 is
    // all nines (a == b), which turns the would-be negative zero into +0.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign b_nc[4*g +: 4]    = nines_comp(b[4*g +: 4]);
        assign mag_neg[4*g +: 4] = nines_comp(sum1[4*g +: 4]);
        assign dig_bad[g]        = !is_bcd(a[4*g +: 4])
                                 || !is_bcd(b[4*g +: 4]);

        bcd_digit_adder u_add (
            .x    (a[4*g +: 4]),
            .y    (b_nc[4*g +: 4]),
            .cin  (c1[g]),
            .sum  (sum1[4*g +: 4]),
            .cout (c1[g+1])
        );

        bcd_digit_adder u_eac (
            .x    (sum1[4*g +: 4]),
            .y    (4'd0),
            .cin  (c2[g]),
            .sum  (sum2[4*g +: 4]),
            .cout (c2[g+1])
        );
    end

    always_comb begin
        nonneg = c1[NUM_DIGITS] | c2[NUM_DIGITS];
        err_d  = |dig_bad;
        s_d    = nonneg ? sum2 : mag_neg;
        cout_d = nonneg;
        if (err_d) begin
            s_d    = '0;
            cout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                err_q  <= err_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_subtractor.sv
// Scoreboard bench for bcd_subtractor at 1 and 2 digits.
module tb_bcd_subtractor;

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       err;
    } exp_t;

    typedef struct {
        bit         two;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       cout;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv1, iv2;
    logic [3:0] a1, b1, s1;
    logic [7:0] a2, b2, s2;
    logic       ov1, ov2, co1, co2, er1, er2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_subtractor #(.NUM_DIGITS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .a         (a1),
        .b         (b1),
        .out_valid (ov1),
        .s         (s1),
        .cout      (co1),
        .err       (er1)
    );

    bcd_subtractor #(.NUM_DIGITS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv2),
        .a         (a2),
        .b         (b2),
        .out_valid (ov2),
        .s         (s2),
        .cout      (co2),
        .err       (er2)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a,
                                   input logic [7:0] b, input int nd);
        exp_t r;
        int av, bv, d;
        logic [3:0] da, db;
        bit bad;
        av = 0; bv = 0; bad = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            da = a[4*i +: 4];
            db = b[4*i +: 4];
            if (da > 4'd9 || db > 4'd9) bad = 1;
            av = av * 10 + int'(da);
            bv = bv * 10 + int'(db);
        end
        r.s = 8'h00;
        r.err = bad;
        r.cout = 1'b0;
        if (!bad) begin
            d = av - bv;
            r.cout = (d >= 0);
            if (d < 0) d = -d;
            for (int i = 0; i < nd; i++) begin
                r.s[4*i +: 4] = 4'(d % 10);
                d = d / 10;
            end
        end
        return r;
    endfunction

    task automatic drive(input bit two, input logic [7:0] a,
                         input logic [7:0] b, input exp_t e,
                         input bit push);
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv2 = 1'b0;
        if (two) begin
            iv2 = 1'b1; a2 = a; b2 = b;
            if (push) q2.push_back(e);
        end else begin
            iv1 = 1'b1; a1 = a[3:0]; b1 = b[3:0];
            if (push) q1.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ov1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb1_unexpected got=out_valid want=idle");
            end else begin
                e1 = q1.pop_front();
                chk("sb1_s", {4'h0, s1}, e1.s);
                chk("sb1_cout", {7'd0, co1}, {7'd0, e1.cout});
                chk("sb1_err", {7'd0, er1}, {7'd0, e1.err});
            end
        end
        if (ov2) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb2_unexpected got=out_valid want=idle");
            end else begin
                e2 = q2.pop_front();
                chk("sb2_s", s2, e2.s);
                chk("sb2_cout", {7'd0, co2}, {7'd0, e2.cout});
                chk("sb2_err", {7'd0, er2}, {7'd0, e2.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        exp_t e;
        logic [7:0] ra, rb;
        int n;

        tbl.push_back('{1'b0, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h3, 8'h2, 8'h1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h7, 8'h4, 8'h3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h8, 8'h9, 8'h1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h4, 8'h5, 8'h1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h0, 8'h9, 8'h9, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'hA, 8'h8, 8'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h9, 8'h9, 8'h0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h3, 8'hF, 8'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 8'h52, 8'h37, 8'h15, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'h10, 8'h95, 8'h85, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h99, 8'h99, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'h99, 8'h99, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h40, 8'h01, 8'h39, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'h3B, 8'h12, 8'h00, 1'b0, 1'b1});

        rst_n = 1'b0;
        iv1 = 1'b1; a1 = 4'd3; b1 = 4'd2;
        iv2 = 1'b0; a2 = 8'h0; b2 = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ov", {7'd0, ov1}, 8'd0);
        chk("rst_s", {4'h0, s1}, 8'd0);
        chk("rst_cout", {7'd0, co1}, 8'd0);
        chk("rst_err", {7'd0, er1}, 8'd0);

        @(posedge clk);
        #1;
        iv1 = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rel_ov", {7'd0, ov1}, 8'd0);
        end

        foreach (tbl[i]) begin
            e = '{tbl[i].s, tbl[i].cout, tbl[i].err};
            drive(tbl[i].two, tbl[i].a, tbl[i].b, e, 1'b1);
        end
        idle();

        drive(1'b0, 8'h7, 8'h4, '{8'h3, 1'b1, 1'b0}, 1'b1);
        drive(1'b0, 8'h2, 8'h6, '{8'h4, 1'b0, 1'b0}, 1'b1);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("hold_ov", {7'd0, ov1}, 8'd0);
        chk("hold_s", {4'h0, s1}, 8'h4);
        chk("hold_cout", {7'd0, co1}, 8'd0);

        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                ra = 8'(x);
                rb = 8'(y);
                drive(1'b0, ra, rb, model(ra, rb, 1), 1'b1);
            end
        end

        for (int k = 0; k < 40; k++) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 10))};
            rb = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 9))};
            drive(1'b1, ra, rb, model(ra, rb, 2), 1'b1);
        end
        idle();
        repeat (3) @(posedge clk);

        drive(1'b0, 8'h7, 8'h4, '{8'h3, 1'b1, 1'b0}, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_arst_ov", {7'd0, ov1}, 8'd1);
        chk("pre_arst_s", {4'h0, s1}, 8'h3);
        iv1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", {7'd0, ov1}, 8'd0);
        chk("arst_s", {4'h0, s1}, 8'd0);
        chk("arst_cout", {7'd0, co1}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_arst_ov", {7'd0, ov1}, 8'd0);

        n = q1.size();
        chk("sb1_pending", 8'(n), 8'd0);
        n = q2.size();
        chk("sb2_pending", 8'(n), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
